// File: rtl/complex_addsub_pipe.sv
// Packed complex add/sub (A +/- B, optional conj(B)) with saturate/wrap, overflow flags and event counter.
// Latency PIPE_STAGES ce-high cycles, one sample per cycle; no backpressure, ce=0 freezes every register.
module complex_addsub_pipe #(
    parameter int W           = 32,
    parameter int PIPE_STAGES = 2,
    parameter int SATURATE    = 1,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [1:0]         mode,
    input  logic [2*W-1:0]     A,
    input  logic [2*W-1:0]     B,
    input  logic               cnt_clr,
    output logic [2*W-1:0]     result,
    output logic               out_valid,
    output logic               ovf_re,
    output logic               ovf_im,
    output logic [COUNT_W-1:0] ovf_count
);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W:0] addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
        logic [W:0] xe;
        logic [W:0] ye;
        xe = {x[W-1], x};
        ye = {y[W-1], y};
        return sub ? (xe - ye) : (xe + ye);
    endfunction

    // The sign of the W+1-bit result picks the clamp direction.
    function automatic logic [W-1:0] clip(input logic [W:0] s);
        if ((SATURATE != 0) && (s[W] != s[W-1]))
            return s[W] ? MAX_NEG : MAX_POS;
        return s[W-1:0];
    endfunction

    logic [W:0] sum_re;
    logic [W:0] sum_im;

    assign sum_re = addsub(A[2*W-1:W], B[2*W-1:W], mode[0]);
    assign sum_im = addsub(A[W-1:0], B[W-1:0], mode[0] ^ mode[1]);

    logic [PIPE_STAGES-1:0]          vld_d, ore_d, oim_d;
    logic [PIPE_STAGES-1:0]          vld_q, ore_q, oim_q;
    logic [PIPE_STAGES-1:0][2*W-1:0] dat_d, dat_q;
    logic                            cnt_inc;

    always_comb begin
        vld_d[0] = in_valid;
        ore_d[0] = in_valid & (sum_re[W] ^ sum_re[W-1]);
        oim_d[0] = in_valid & (sum_im[W] ^ sum_im[W-1]);
        dat_d[0] = {clip(sum_re), clip(sum_im)};
        for (int i = 1; i < PIPE_STAGES; i++) begin
            vld_d[i] = vld_q[i-1];
            ore_d[i] = ore_q[i-1];
            oim_d[i] = oim_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Count on the edge that loads the sample into the output stage.
    assign cnt_inc = vld_d[PIPE_STAGES-1] & (ore_d[PIPE_STAGES-1] | oim_d[PIPE_STAGES-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            ore_q     <= '0;
            oim_q     <= '0;
            dat_q     <= '0;
            ovf_count <= '0;
        end else if (ce) begin
            vld_q <= vld_d;
            ore_q <= ore_d;
            oim_q <= oim_d;
            dat_q <= dat_d;
            if (cnt_clr)
                ovf_count <= '0;
            else if (cnt_inc && !(&ovf_count))
                ovf_count <= ovf_count + COUNT_W'(1);
        end
    end

    assign result    = dat_q[PIPE_STAGES-1];
    assign out_valid = vld_q[PIPE_STAGES-1];
    assign ovf_re    = ore_q[PIPE_STAGES-1];
    assign ovf_im    = oim_q[PIPE_STAGES-1];

endmodule

// File: doc/complex_addsub_pipe.md
Name: complex_addsub_pipe

Overview:
- Parametrised successor to the team's complex adder/subtractor, using fixed-point two's-complement components.
- Packed complex word: real part in the upper W bits, imaginary part in the lower W bits.
- Adds a per-sample mode (add, sub, add-conjugate, sub-conjugate), configurable pipeline depth, valid tracking, optional saturation, overflow flags and a saturating overflow-event counter.
- Sits in the complex datapath wherever operands are combined ahead of the multiplier and accumulator stages.

Parameters:
W, 32, bit width of each real/imag component (min 4)
PIPE_STAGES, 2, latency in ce-qualified cycles (1..4)
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
COUNT_W, 16, width of overflow event counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ce  in  1  clock enable; 0 freezes entire pipeline and counter
in_valid  in  1  A/B/mode qualify this cycle
mode  in  2  bit0: 0 = add, 1 = sub; bit1: 1 = conjugate B first
A  in  2*W  operand {A_re, A_im}
B  in  2*W  operand {B_re, B_im}
cnt_clr  in  1  clears ovf_count
result  out  2*W  {R_re, R_im}
out_valid  out  1  result qualifier
ovf_re  out  1  real component overflowed (before sat/wrap)
ovf_im  out  1  imag component overflowed
ovf_count  out  COUNT_W  number of emitted valid samples with any overflow

Behaviour:
- Reset is synchronous. When rst=1 at a clock edge, all of the following clear to 0 regardless of ce: result, out_valid, ovf_re, ovf_im, ovf_count and every internal valid/data register. Samples in flight when reset is asserted are discarded.
- Operation select, all signed:
  - Real component: R_re = A_re + B_re if mode[0]=0, A_re - B_re if mode[0]=1.
  - Imag component: imag_sub = mode[0] XOR mode[1]. R_im = A_im - B_im if imag_sub=1, otherwise A_im + B_im.
  - Resulting modes: 00 = A+B; 01 = A-B; 10 = A+conj(B); 11 = A-conj(B).
- Arithmetic: operands are sign-extended to W+1 bits and the sum or difference is computed at W+1 bits.
  - Overflow occurs when bit W differs from bit W-1.
  - SATURATE=1: a positive overflow clamps to 2^(W-1)-1 and a negative overflow clamps to -2^(W-1).
  - SATURATE=0: keep the low W bits (wrap).
  - The ovf flags are reported in both modes.
- Pipeline:
  - Stage 1 registers the computed result, the ovf flags and the valid bit.
  - Stages 2..PIPE_STAGES are pure delay registers.
  - All stages advance only when ce=1. With ce=0, every register holds, including out_valid.
  - Latency is PIPE_STAGES ce-high edges from input to output.
  - Full throughput: one sample per ce-high cycle, no bubbles required.
- Invalid samples: when in_valid=0 the stage-1 valid bit loads 0. Data registers load anyway, so their contents are don't-care.
  - ovf_re and ovf_im are forced to 0 whenever the corresponding valid bit is 0.
  - result is don't-care when out_valid=0. The bench must not check it.
- ovf_count:
  - On a ce=1 edge where the last stage loads valid=1 with (ovf_re | ovf_im), the counter increments at the same edge out_valid rises for that sample.
  - The counter saturates at all-ones; it does not wrap.
  - cnt_clr=1 clears the counter to 0 and overrides a simultaneous increment.
  - cnt_clr acts only when ce=1.
  - rst overrides everything.
- Mode and operands are sampled only at the stage-1 load, so changing mode mid-stream affects only subsequent samples.

Test Plan:
1. Basic modes, W=16, PIPE_STAGES=2. A={100,50}, B={30,20} sent with mode 00/01/10/11 on consecutive cycles. Required results, 2 cycles later and back-to-back: {130,70}, {70,30}, {130,30}, {70,70}. out_valid is high for 4 cycles and all ovf flags are 0.
2. Saturation, SATURATE=1, W=16. A={32767,-32768}, B={1,1}, mode 01. Required: result {32766,-32768}, ovf_im=1, ovf_re=0, ovf_count=1. Then mode 00 with the same operands: result {32767,-32767}, ovf_re=1, ovf_im=0, ovf_count=2.
3. Wrap, SATURATE=0. A={32767,0}, B={1,0}, mode 00. Required: result {-32768,0}, ovf_re=1, ovf_count increments.
4. ce stall. Stream 5 valid samples, drop ce for 3 cycles mid-stream. Required: outputs freeze (values and out_valid held), then resume with no sample lost or duplicated; total latency equals PIPE_STAGES ce-high edges.
5. Counter limits, COUNT_W=4. Drive 20 overflowing samples: ovf_count stops at 15. Then assert cnt_clr together with an overflowing output: the count reads 0, not 1.
6. Reset mid-operation. Assert rst for 1 cycle with 2 samples in flight, ce=0. Required: the next cycle shows out_valid=0, result=0, ovf_count=0, and the in-flight samples never appear at the output.
